// File: rtl/nco_harmonic_bank_pkg.sv
// Shared types and constants for the harmonic NCO bank: quadrant encoding,
// quarter-wave LUT sizing/contents, harmonic output slicing and LFSR constants.
package nco_pkg;

    // Quadrant of one full sine cycle, taken from the top two phase bits.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    // Galois LFSR x^16+x^14+x^13+x^11+1, right-shifting form.
    localparam logic [15:0] LfsrPoly = 16'hB400;
    localparam logic [15:0] LfsrSeed = 16'hACE1;

    localparam real Pi = 3.14159265358979323846;

    // Entries in one quarter-wave table for a full-cycle address of addr_w bits.
    function automatic int unsigned lut_depth(input int unsigned addr_w);
        return 32'd1 << (addr_w - 2);
    endfunction

    // LSB position of harmonic k (1-based) within the packed sample bus.
    function automatic int unsigned harm_lsb(input int unsigned k, input int unsigned out_width);
        return (k - 1) * out_width;
    endfunction

    // Quarter-wave entry sampled at the bin centre, so the fold in the other
    // three quadrants reproduces the full-cycle table exactly.
    function automatic int lut_entry(input int unsigned idx, input int unsigned addr_w,
                                     input int unsigned out_w);
        real amp;
        real ang;
        amp = real'((32'd1 << (out_w - 1)) - 32'd1);
        ang = 2.0 * Pi * (real'(idx) + 0.5) / real'(32'd1 << addr_w);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_harmonic_bank_if.sv
// Frequency-update handshake between the control register file and the NCO bank.
interface nco_harmonic_bank_if #(
    parameter int unsigned PHASE_W = 32
);
    logic [PHASE_W-1:0] phi_inc_i;
    logic               phi_inc_valid_i;
    logic               phi_inc_ready_o;

    modport master (
        output phi_inc_i,
        output phi_inc_valid_i,
        input  phi_inc_ready_o
    );

    modport slave (
        input  phi_inc_i,
        input  phi_inc_valid_i,
        output phi_inc_ready_o
    );
endinterface

// File: rtl/nco_quarter_lut.sv
// Registered-read quarter-wave sine ROM; returns the positive magnitude only.
module nco_quarter_lut
    import nco_pkg::*;
#(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned OUT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic [ADDR_W-3:0]    addr,
    output logic [OUT_WIDTH-1:0] q_o
);

    localparam int unsigned Depth = lut_depth(ADDR_W);

    logic [OUT_WIDTH-1:0] rom [Depth];

    for (genvar i = 0; i < int'(Depth); i++) begin : g_rom
        localparam logic [OUT_WIDTH-1:0] Entry = OUT_WIDTH'(lut_entry(i, ADDR_W, OUT_WIDTH));
        assign rom[i] = Entry;
    end

    // Synchronous ROM read
    always_ff @(posedge clk) begin
        q_o <= rom[addr];
    end

endmodule

// File: rtl/nco_harmonic_bank.sv
// Phase-accumulator NCO producing NUM_HARM phase-coherent harmonics of one tone.
// Pipeline: stage 0 accumulator, stage 1 harmonic phase fold, stage 2 LUT read,
// stage 3 sign restore. Optional feature macro: NCO_PHASE_DITHER_EN adds LFSR
// dither below the LUT address LSB before truncation.
module nco_harmonic_bank
    import nco_pkg::*;
#(
    parameter int unsigned PHASE_W   = 32,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned OUT_WIDTH = 10,
    parameter int unsigned NUM_HARM  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clken,
    nco_harmonic_bank_if.slave            inc_if,
    input  logic                          phase_sync_i,
    input  logic [PHASE_W-1:0]            phase_ofs_i,
    output logic [NUM_HARM*OUT_WIDTH-1:0] fsin_o,
    output logic                          out_valid,
    output logic                          wrap_o
);

    localparam int unsigned IdxW = ADDR_W - 2;

    // Stage 0 state
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [PHASE_W-1:0] pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               sync_pend_q, sync_pend_d;
    logic [PHASE_W-1:0] ofs_pend_q, ofs_pend_d;
    logic               v0_q, v0_d;
    logic               wrap0_q, wrap0_d;
    logic [PHASE_W:0]   sum;
    logic               inc_ready;

    // Valid/wrap flags travelling alongside the sample
    logic v1_q, w1_q, v2_q, w2_q, v3_q, w3_q;

    logic [PHASE_W-1:0] dither;

    assign inc_ready              = ~pend_vld_q;
    assign inc_if.phi_inc_ready_o = inc_ready;

    // Accumulator step, sync reload and increment handshake
    always_comb begin
        sum         = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d       = acc_q;
        wrap0_d     = 1'b0;
        v0_d        = clken;
        inc_d       = inc_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        sync_pend_d = sync_pend_q;
        ofs_pend_d  = ofs_pend_q;
        if (clken) begin
            sync_pend_d = 1'b0;
            if (phase_sync_i) begin
                acc_d = phase_ofs_i;
            end else if (sync_pend_q) begin
                acc_d = ofs_pend_q;
            end else begin
                acc_d   = sum[PHASE_W-1:0];
                wrap0_d = sum[PHASE_W];
            end
            // Old increment drives this step; the new one applies from the next clken.
            if (pend_vld_q) begin
                inc_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (phase_sync_i) begin
            sync_pend_d = 1'b1;
            ofs_pend_d  = phase_ofs_i;
        end
        // Capture cannot collide with transfer: ready is low while a value is pending.
        if (inc_if.phi_inc_valid_i && inc_ready) begin
            pend_d     = inc_if.phi_inc_i;
            pend_vld_d = 1'b1;
        end
    end

    // Stage 0 registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            inc_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            sync_pend_q <= 1'b0;
            ofs_pend_q  <= '0;
            v0_q        <= 1'b0;
            wrap0_q     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            sync_pend_q <= sync_pend_d;
            ofs_pend_q  <= ofs_pend_d;
            v0_q        <= v0_d;
            wrap0_q     <= wrap0_d;
        end
    end

`ifdef NCO_PHASE_DITHER_EN
    localparam int unsigned DitherW = (PHASE_W - ADDR_W > 16) ? 16 : (PHASE_W - ADDR_W);

    logic [15:0] lfsr_q, lfsr_d;

    // LFSR advances with the accumulator so dither stays aligned with acc_q
    always_comb begin
        lfsr_d = lfsr_q;
        if (clken) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0000);
        end
    end

    // LFSR register
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither = PHASE_W'(lfsr_q[15 -: DitherW]) << (PHASE_W - ADDR_W - DitherW);
`else
    assign dither = '0;
`endif

    // Valid and wrap flags follow the sample through stages 1..3
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
            w1_q <= 1'b0;
            v2_q <= 1'b0;
            w2_q <= 1'b0;
            v3_q <= 1'b0;
            w3_q <= 1'b0;
        end else begin
            v1_q <= v0_q;
            w1_q <= v0_q & wrap0_q;
            v2_q <= v1_q;
            w2_q <= w1_q;
            v3_q <= v2_q;
            w3_q <= w2_q;
        end
    end

    assign out_valid = v3_q;
    assign wrap_o    = w3_q;

    for (genvar k = 1; k <= int'(NUM_HARM); k++) begin : g_harm
        logic [ADDR_W-1:0]    ph_top;
        quadrant_e            quad_d, quad1_q, quad2_q;
        logic [IdxW-1:0]      idx_d, idx1_q;
        logic [OUT_WIDTH-1:0] mag;
        logic [OUT_WIDTH-1:0] samp_d, samp_q;

        // Harmonic phase (mod 2^PHASE_W), truncated and folded to a quarter-wave index
        always_comb begin
            ph_top = ADDR_W'((acc_q * PHASE_W'(k) + dither) >> (PHASE_W - ADDR_W));
            quad_d = quadrant_e'(ph_top[ADDR_W-1 -: 2]);
            idx_d  = ph_top[IdxW-1:0];
            if (quad_d == Q1 || quad_d == Q3) begin
                idx_d = ~idx_d;
            end
        end

        // Stage 1 index/quadrant and stage 2 quadrant delay; qualified by the valid pipe
        always_ff @(posedge clk) begin
            idx1_q  <= idx_d;
            quad1_q <= quad_d;
            quad2_q <= quad1_q;
        end

        nco_quarter_lut #(
            .ADDR_W   (ADDR_W),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_lut (
            .clk (clk),
            .addr(idx1_q),
            .q_o (mag)
        );

        // Restore sign for the negative half-cycle; hold between strobes
        always_comb begin
            samp_d = samp_q;
            if (v2_q) begin
                samp_d = (quad2_q inside {Q2, Q3}) ? ('0 - mag) : mag;
            end
        end

        // Stage 3 output register
        always_ff @(posedge clk) begin
            if (reset) begin
                samp_q <= '0;
            end else begin
                samp_q <= samp_d;
            end
        end

        assign fsin_o[harm_lsb(k, OUT_WIDTH) +: OUT_WIDTH] = samp_q;
    end

endmodule

// File: tb/tb_nco_harmonic_bank.sv
// Self-checking bench for nco_harmonic_bank: directed scenarios followed by
// random traffic, compared against a delay-queue reference model.
module tb_nco_harmonic_bank;

    localparam int unsigned PhaseW  = 32;
    localparam int unsigned AddrW   = 12;
    localparam int unsigned OutW    = 10;
    localparam int unsigned NumHarm = 2;
    localparam int unsigned Latency = 3;
    localparam real         TbPi    = 3.14159265358979323846;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      clken;
    logic                      phase_sync_i;
    logic [PhaseW-1:0]         phase_ofs_i;
    logic [NumHarm*OutW-1:0]   fsin_o;
    logic                      out_valid;
    logic                      wrap_o;

    nco_harmonic_bank_if #(.PHASE_W(PhaseW)) inc_if ();

    nco_harmonic_bank #(
        .PHASE_W  (PhaseW),
        .ADDR_W   (AddrW),
        .OUT_WIDTH(OutW),
        .NUM_HARM (NumHarm)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clken       (clken),
        .inc_if      (inc_if),
        .phase_sync_i(phase_sync_i),
        .phase_ofs_i (phase_ofs_i),
        .fsin_o      (fsin_o),
        .out_valid   (out_valid),
        .wrap_o      (wrap_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        bit          wrap;
        int          h1;
        int          h2;
    } samp_t;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    samp_t       exp_q[$];
    logic [31:0] m_acc, m_inc, m_pend, m_ofs;
    bit          m_pend_vld, m_sync_pend;
    bit          exp_valid, exp_wrap;
    int          exp_h1, exp_h2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Ideal full-cycle sine at the truncated harmonic phase, rounded to nearest.
    function automatic int ref_sample(input logic [31:0] acc, input int k);
        longint unsigned prod;
        int              p;
        real             r;
        prod = (longint'(acc) * longint'(k)) % 64'h1_0000_0000;
        p    = int'(prod >> (PhaseW - AddrW));
        r    = real'((1 << (OutW - 1)) - 1) *
               $sin(2.0 * TbPi * (real'(p) + 0.5) / real'(1 << AddrW));
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(0.5 - r);
    endfunction

    // Effect of the coming clock edge on the reference state.
    task automatic model_edge();
        samp_t           s;
        longint unsigned t;
        bit              rdy;
        bit              w;
        cyc++;
        if (reset) begin
            m_acc = '0; m_inc = '0; m_pend = '0; m_ofs = '0;
            m_pend_vld = 1'b0; m_sync_pend = 1'b0;
            exp_q.delete();
            exp_valid = 1'b0; exp_wrap = 1'b0; exp_h1 = 0; exp_h2 = 0;
            return;
        end
        exp_valid = 1'b0;
        exp_wrap  = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            s = exp_q.pop_front();
            exp_valid = 1'b1;
            exp_wrap  = s.wrap;
            exp_h1    = s.h1;
            exp_h2    = s.h2;
        end
        rdy = !m_pend_vld;
        if (clken) begin
            w = 1'b0;
            if (phase_sync_i) begin
                m_acc = phase_ofs_i;
            end else if (m_sync_pend) begin
                m_acc = m_ofs;
            end else begin
                t     = longint'(m_acc) + longint'(m_inc);
                w     = (t >= 64'h1_0000_0000);
                m_acc = t[31:0];
            end
            m_sync_pend = 1'b0;
            if (m_pend_vld) begin
                m_inc      = m_pend;
                m_pend_vld = 1'b0;
            end
            s.due  = cyc + Latency;
            s.wrap = w;
            s.h1   = ref_sample(m_acc, 1);
            s.h2   = ref_sample(m_acc, 2);
            exp_q.push_back(s);
        end else if (phase_sync_i) begin
            m_sync_pend = 1'b1;
            m_ofs       = phase_ofs_i;
        end
        if (inc_if.phi_inc_valid_i && rdy) begin
            m_pend     = inc_if.phi_inc_i;
            m_pend_vld = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e1, e2;
        e1 = exp_h1;
        e2 = exp_h2;
        check_eq("ready", 32'(inc_if.phi_inc_ready_o), 32'(!m_pend_vld));
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        check_eq("wrap_o", 32'(wrap_o), 32'(exp_wrap));
        check_eq("h1", 32'(fsin_o[OutW-1:0]), 32'(e1[OutW-1:0]));
        check_eq("h2", 32'(fsin_o[2*OutW-1:OutW]), 32'(e2[OutW-1:0]));
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input bit rst, input bit ce, input bit vld, input logic [31:0] inc,
                         input bit sync, input logic [31:0] ofs);
        reset                  = rst;
        clken                  = ce;
        inc_if.phi_inc_valid_i = vld;
        inc_if.phi_inc_i       = inc;
        phase_sync_i           = sync;
        phase_ofs_i            = ofs;
        @(negedge clk);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        reset                  = 1'b1;
        clken                  = 1'b1;
        inc_if.phi_inc_valid_i = 1'b0;
        inc_if.phi_inc_i       = '0;
        phase_sync_i           = 1'b0;
        phase_ofs_i            = '0;

        // Reset held with clken high
        repeat (3) cycle(1, 1, 0, 32'h0, 0, 32'h0);

        // Quarter-cycle steps, clken every cycle
        cycle(0, 0, 1, 32'h4000_0000, 0, 32'h0);
        repeat (18) cycle(0, 1, 0, 32'h0, 0, 32'h0);

        // Sparse clken: every third cycle
        for (int i = 0; i < 27; i++) cycle(0, (i % 3) == 0, 0, 32'h0, 0, 32'h0);

        // Frequency change while running; ready stays low until a clken
        cycle(0, 0, 1, 32'h2000_0000, 0, 32'h0);
        cycle(0, 0, 1, 32'h1234_5678, 0, 32'h0);
        repeat (14) cycle(0, 1, 0, 32'h0, 0, 32'h0);

        // Phase sync on a clken cycle, then sync held without clken
        cycle(0, 1, 0, 32'h0, 1, 32'h4000_0000);
        repeat (5) cycle(0, 1, 0, 32'h0, 0, 32'h0);
        cycle(0, 0, 0, 32'h0, 1, 32'hC000_0000);
        cycle(0, 0, 0, 32'h0, 0, 32'h0);
        repeat (5) cycle(0, 1, 0, 32'h0, 0, 32'h0);

        // Reset one cycle after clken drops the in-flight sample
        cycle(0, 1, 0, 32'h0, 0, 32'h0);
        cycle(1, 0, 0, 32'h0, 0, 32'h0);
        repeat (5) cycle(0, 0, 0, 32'h0, 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom(),
                  $urandom_range(0, 31) == 0, $urandom());
        end

        // Drain
        repeat (6) cycle(0, 0, 0, 32'h0, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
